// File: rtl/mld_15_7_decoder.sv
// mld_15_7_decoder: serial-in one-step majority-logic decoder for the (15,7) cyclic code
module mld_15_7_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_bit,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [14:0] codeword_out,
  output logic [6:0]  data_out,
  output logic [3:0]  err_count,
  output logic        out_valid
);
  typedef enum logic {LOAD, DECODE} state_t;
  state_t      state_q, state_d;
  logic [14:0] buf_q, buf_d, cw_q, cw_d;
  logic [3:0]  cnt_q, cnt_d, flips_q, flips_d, err_q, err_d;
  logic        ov_q, ov_d;
  logic [3:0]  a;
  logic [2:0]  votes;
  logic        flip;
  always_comb begin
    a[0] = buf_q[7] ^ buf_q[8] ^ buf_q[10] ^ buf_q[14];
    a[1] = buf_q[3] ^ buf_q[11] ^ buf_q[12] ^ buf_q[14];
    a[2] = buf_q[1] ^ buf_q[5] ^ buf_q[13] ^ buf_q[14];
    a[3] = buf_q[0] ^ buf_q[2] ^ buf_q[6] ^ buf_q[14];
    votes = {2'b0, a[0]} + {2'b0, a[1]} + {2'b0, a[2]} + {2'b0, a[3]};
    flip = votes >= 3'd3;
    state_d = state_q;
    buf_d = buf_q;
    cnt_d = cnt_q;
    flips_d = flips_q;
    cw_d = cw_q;
    err_d = err_q;
    ov_d = 1'b0;
    if (state_q == LOAD) begin
      if (rx_valid) begin
        buf_d = {buf_q[13:0], rx_bit};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd14) begin
          state_d = DECODE;
          cnt_d = 4'd0;
          flips_d = 4'd0;
        end
      end
    end else begin
      // rotate position 14 down to 0, correcting it on the way past
      buf_d = {buf_q[13:0], buf_q[14] ^ flip};
      flips_d = flips_q + {3'b0, flip};
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd14) begin
        state_d = LOAD;
        cnt_d = 4'd0;
        cw_d = buf_d;
        err_d = flips_d;
        ov_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      buf_q <= '0;
      cnt_q <= '0;
      flips_q <= '0;
      cw_q <= '0;
      err_q <= '0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      flips_q <= flips_d;
      cw_q <= cw_d;
      err_q <= err_d;
      ov_q <= ov_d;
    end
  end
  assign rx_ready = state_q == LOAD;
  assign codeword_out = cw_q;
  assign data_out = cw_q[14:8];
  assign err_count = err_q;
  assign out_valid = ov_q;
endmodule

// File: tb/tb_mld_15_7_decoder.sv
// tb_mld_15_7_decoder: directed-vector bench for the (15,7) majority-logic decoder
module tb_mld_15_7_decoder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_bit = 1'b0;
  logic        rx_valid = 1'b0;
  logic        rx_ready, out_valid;
  logic [14:0] codeword_out;
  logic [6:0]  data_out;
  logic [3:0]  err_count;
  int          n_chk = 0, n_fail = 0, cyc = 0;
  logic [14:0] r_cw;
  logic [6:0]  r_data;
  logic [3:0]  r_err;
  int          r_lat, r_busy, r_cyc;
  bit          r_seen;
  mld_15_7_decoder dut (
    .clk(clk), .reset(reset), .rx_bit(rx_bit), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .codeword_out(codeword_out), .data_out(data_out), .err_count(err_count), .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // called at a negedge; returns at the negedge of the out_valid cycle (or the cycle after the last bit)
  task automatic send_word(input logic [14:0] w, input logic [14:0] stall_mask, input bit poke, input bit wait_ov);
    for (int i = 14; i >= 0; i--) begin
      if (stall_mask[i]) begin
        rx_valid = 1'b0;
        @(negedge clk);
      end
      rx_valid = 1'b1;
      rx_bit = w[i];
      @(negedge clk);
    end
    rx_valid = 1'b0;
    r_seen = 1'b0;
    r_busy = 0;
    r_lat = 0;
    if (wait_ov) begin
      for (int n = 1; n <= 40 && !r_seen; n++) begin
        r_lat = n;
        if (!rx_ready) r_busy++;
        if (out_valid) begin
          r_seen = 1'b1;
          r_cw = codeword_out;
          r_data = data_out;
          r_err = err_count;
          r_cyc = cyc;
          rx_valid = 1'b0;
        end else begin
          rx_valid = poke && n[0];
          rx_bit = 1'($urandom_range(1));
          @(negedge clk);
        end
      end
      rx_valid = 1'b0;
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_chk++;
    if (rx_ready !== 1'b1 || out_valid !== 1'b0 || codeword_out !== 15'h0 || data_out !== 7'h0 || err_count !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b ov=%b cw=%h data=%h err=%0d, required rdy=1 ov=0 cw=0000 data=00 err=0",
               rx_ready, out_valid, codeword_out, data_out, err_count);
    end
  endtask
  task automatic test_zero_word;
    send_word(15'h0000, 15'h0, 1'b0, 1'b1);
    n_chk++;
    if (!r_seen || r_lat != 16) begin
      n_fail++;
      $display("FAIL zero_latency: seen=%b lat=%0d, required seen=1 lat=16", r_seen, r_lat);
    end
    n_chk++;
    if (r_cw !== 15'h0000 || r_data !== 7'h00 || r_err !== 4'd0) begin
      n_fail++;
      $display("FAIL zero_word: cw=%h data=%h err=%0d, required 0000/00/0", r_cw, r_data, r_err);
    end
  endtask
  task automatic test_stall;
    send_word(15'h01D1, 15'b000_1000_1000_0100, 1'b0, 1'b1);
    n_chk++;
    if (!r_seen || r_lat != 16 || r_busy != 15) begin
      n_fail++;
      $display("FAIL stall_timing: seen=%b lat=%0d busy=%0d, required 1/16/15", r_seen, r_lat, r_busy);
    end
    n_chk++;
    if (r_cw !== 15'h01D1 || r_data !== 7'h01 || r_err !== 4'd0) begin
      n_fail++;
      $display("FAIL stall_word: cw=%h data=%h err=%0d, required 01d1/01/0", r_cw, r_data, r_err);
    end
  endtask
  task automatic test_single_err;
    logic [14:0] one = 15'd1;
    for (int i = 0; i < 15; i++) begin
      send_word(15'h01D1 ^ (one << i), 15'h0, 1'b0, 1'b1);
      n_chk++;
      if (!r_seen || r_cw !== 15'h01D1 || r_err !== 4'd1) begin
        n_fail++;
        $display("FAIL single_err[%0d]: seen=%b cw=%h err=%0d, required 01d1/1", i, r_seen, r_cw, r_err);
      end
    end
  endtask
  task automatic test_double_err;
    logic [14:0] one = 15'd1;
    logic [14:0] base;
    for (int b = 0; b < 2; b++) begin
      base = b == 0 ? 15'h0000 : 15'h01D1;
      for (int i = 0; i < 15; i++)
        for (int j = i + 1; j < 15; j++) begin
          send_word(base ^ (one << i) ^ (one << j), 15'h0, 1'b1, 1'b1);
          n_chk++;
          if (!r_seen || r_cw !== base || r_err !== 4'd2 || r_busy != 15) begin
            n_fail++;
            $display("FAIL double_err[%h,%0d,%0d]: seen=%b cw=%h err=%0d busy=%0d, required %h/2/15",
                     base, i, j, r_seen, r_cw, r_err, r_busy, base);
          end
        end
    end
  endtask
  task automatic test_reset_mid_decode;
    int ov_seen = 0;
    send_word(15'h01D1 ^ 15'h0208, 15'h0, 1'b0, 1'b0);
    for (int n = 1; n < 7; n++) begin
      if (out_valid) ov_seen++;
      @(negedge clk);
    end
    reset = 1'b1;
    rx_valid = 1'b1;
    rx_bit = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rx_valid = 1'b0;
    n_chk++;
    if (rx_ready !== 1'b1 || out_valid !== 1'b0 || codeword_out !== 15'h0 || data_out !== 7'h0 || err_count !== 4'h0) begin
      n_fail++;
      $display("FAIL abort_reset: rdy=%b ov=%b cw=%h data=%h err=%0d, required 1/0/0000/00/0",
               rx_ready, out_valid, codeword_out, data_out, err_count);
    end
    for (int n = 0; n < 20; n++) begin
      if (out_valid) ov_seen++;
      @(negedge clk);
    end
    n_chk++;
    if (ov_seen != 0) begin
      n_fail++;
      $display("FAIL abort_no_ov: out_valid pulses=%0d, required 0", ov_seen);
    end
    send_word(15'h01D1, 15'h0, 1'b0, 1'b1);
    n_chk++;
    if (!r_seen || r_cw !== 15'h01D1 || r_err !== 4'd0) begin
      n_fail++;
      $display("FAIL abort_next: seen=%b cw=%h err=%0d, required 01d1/0", r_seen, r_cw, r_err);
    end
  endtask
  task automatic test_back_to_back;
    int c1;
    send_word(15'h01D1 ^ 15'h4000, 15'h0, 1'b0, 1'b1);
    c1 = r_cyc;
    n_chk++;
    if (!r_seen || r_cw !== 15'h01D1 || r_err !== 4'd1) begin
      n_fail++;
      $display("FAIL b2b_first: seen=%b cw=%h err=%0d, required 01d1/1", r_seen, r_cw, r_err);
    end
    send_word(15'h0408, 15'h0, 1'b0, 1'b1);
    n_chk++;
    if (!r_seen || r_cw !== 15'h0000 || r_err !== 4'd2) begin
      n_fail++;
      $display("FAIL b2b_second: seen=%b cw=%h err=%0d, required 0000/2", r_seen, r_cw, r_err);
    end
    n_chk++;
    if (r_cyc - c1 != 30) begin
      n_fail++;
      $display("FAIL b2b_period: period=%0d, required 30", r_cyc - c1);
    end
  endtask
  initial begin
    test_reset();
    test_zero_word();
    test_stall();
    test_single_err();
    test_double_err();
    test_reset_mid_decode();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
